aes_cbc_dec_chain: RTL and testbench

//   CBC post-processor directly downstream of the pipelined AES decrypt core.
//   - Holds a copy of every ciphertext block sent into the core.
//   - XORs each raw core output with the previous ciphertext block (the IV for the first block).
//   - Emits registered CBC plaintext.
//   - The core has no backpressure, so this block tracks in-flight blocks and flags protocol errors.

---
 rtl/aes_cbc_dec_chain_pkg.sv | 12 +
 rtl/aes_cbc_dec_chain_if.sv | 29 ++
 rtl/aes_cbc_dec_chain_ct_fifo.sv | 59 +++++
 rtl/aes_cbc_dec_chain.sv | 74 +++++++
 tb/tb_aes_cbc_dec_chain.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_cbc_dec_chain_pkg.sv
// Shared AES block type and core-latency helper for the CBC decrypt chain.
// Combinational definitions only; no state, no backpressure.
package aes_cbc_dec_chain_pkg;

  typedef logic [127:0] block_t;

  // Load-to-pt_valid latency of the pipelined decrypt core for a given round count.
  function automatic int aes_latency(input int nr);
    return nr + 2;
  endfunction

endpackage

// File: rtl/aes_cbc_dec_chain_if.sv
// Core-side strobes in, CBC plaintext and status out; the core has no backpressure.
// master drives ct/iv/core outputs, slave is the CBC post-processor.
interface aes_cbc_dec_chain_if #(parameter int DEPTH = 12);
  import aes_cbc_dec_chain_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic          iv_load;
  block_t        iv;
  logic          ct_load;
  block_t        ct;
  logic          pt_valid;
  block_t        pt_raw;
  logic          out_valid;
  block_t        out_pt;
  logic [CW-1:0] inflight;
  logic          err;

  modport master (
    output iv_load, iv, ct_load, ct, pt_valid, pt_raw,
    input  out_valid, out_pt, inflight, err
  );

  modport slave (
    input  iv_load, iv, ct_load, ct, pt_valid, pt_raw,
    output out_valid, out_pt, inflight, err
  );

endinterface

// File: rtl/aes_cbc_dec_chain_ct_fifo.sv
// Ciphertext FIFO of arbitrary depth; head is combinational, push/pop take effect on the clock edge.
// No backpressure: an illegal push or pop is simply not performed, full accepts push only with a pop.
module aes_cbc_dec_chain_ct_fifo
  import aes_cbc_dec_chain_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  block_t                     din,
  input  logic                       pop,
  output block_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  block_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Non-power-of-two depth: wrap explicitly at DEPTH-1.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/aes_cbc_dec_chain.sv
// CBC chaining after the AES decrypt core: out_pt = pt_raw ^ previous ct (or IV), registered, 1-cycle latency.
// Core cannot be stalled, so overflow/underflow/late IV loads are dropped and latched in sticky err.
module aes_cbc_dec_chain
  import aes_cbc_dec_chain_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_cbc_dec_chain_if.slave    bus
);

  localparam int NR    = Nk + 6;
  localparam int DEPTH = aes_latency(NR);
  localparam int CW    = $clog2(DEPTH + 1);

  block_t        head;
  block_t        chain;
  block_t        out_pt_q;
  logic          out_valid_q;
  logic          err_q;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  logic pop_ok;
  logic underflow;
  logic overflow;
  logic iv_ok;
  logic iv_bad;

  aes_cbc_dec_chain_ct_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.ct_load),
    .din   (bus.ct),
    .pop   (bus.pt_valid),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign pop_ok    = bus.pt_valid & ~empty;
  assign underflow = bus.pt_valid & empty;
  assign overflow  = bus.ct_load & full & ~pop_ok;
  // An IV may only replace the chain between messages, never under a live block.
  assign iv_ok     = bus.iv_load & (count == '0) & ~pop_ok;
  assign iv_bad    = bus.iv_load & ~iv_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain       <= '0;
      out_pt_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= pop_ok;
      if (pop_ok) begin
        out_pt_q <= bus.pt_raw ^ chain;
        chain    <= head;
      end else if (iv_ok) begin
        chain <= bus.iv;
      end
      if (underflow | overflow | iv_bad) err_q <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pt    = out_pt_q;
  assign bus.inflight  = count;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_aes_cbc_dec_chain.sv
// Directed bench: the bench plays the AES core, feeding pt_raw = plaintext ^ previous ct.
module tb_aes_cbc_dec_chain;
  import aes_cbc_dec_chain_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n_out;
  block_t prev;

  aes_cbc_dec_chain_if #(.DEPTH(12)) bus ();

  aes_cbc_dec_chain #(.Nk(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  localparam block_t NIST_IV = 128'h000102030405060708090a0b0c0d0e0f;
  block_t nct [4] = '{128'h7649abac8119b246cee98e9b12e9197d,
                      128'h5086cb9b507219ee95db113a917678b2,
                      128'h73bed6b8e3c1743b7116e69e22229516,
                      128'h3ff1caa1681fac09120eca307586e1a7};
  block_t npt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                      128'hae2d8a571e03ac9c9eb76fac45af8e51,
                      128'h30c81c46a35ce411e5fbc1191a0a52ef,
                      128'hf69f2445df4f9b17ad2b417be66c3710};

  function automatic block_t ctk(input int k);
    return {32'hc0de0000 + 32'(k), 32'h12345678, 32'h9abcdef0 ^ 32'(k), 32'(k * 3)};
  endfunction

  function automatic block_t ptk(input int k);
    return {32'h5a5a0000 + 32'(k), 32'hfedcba98 ^ 32'(k << 8), 32'h76543210, 32'(k * 7 + 1)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iv_load  = 1'b0;
    bus.ct_load  = 1'b0;
    bus.pt_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input block_t c);
    bus.ct_load = 1'b1;
    bus.ct      = c;
    tick();
    idle();
  endtask

  task automatic load_iv(input block_t v);
    bus.iv_load = 1'b1;
    bus.iv      = v;
    tick();
    idle();
  endtask

  // Core delivers a raw block for plaintext p whose predecessor ciphertext is prev; prev advances to c.
  task automatic pop_chk(input string tag, input block_t p, input block_t c);
    bus.pt_valid = 1'b1;
    bus.pt_raw   = p ^ prev;
    prev         = c;
    tick();
    idle();
    chk({tag, "_vld"}, 128'(bus.out_valid), 128'd1);
    chk({tag, "_pt"}, bus.out_pt, p);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.iv = '0;
    bus.ct = '0;
    bus.pt_raw = '0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_pt", bus.out_pt, 128'd0);
    chk("rst_inflight", 128'(bus.inflight), 128'd0);
    chk("rst_err", 128'(bus.err), 128'd0);
    rst = 1'b0;
    tick();

    // NIST SP800-38A CBC-AES128 blocks 1..4
    load_iv(NIST_IV);
    for (int i = 0; i < 4; i++) push(nct[i]);
    chk("nist_inflight", 128'(bus.inflight), 128'd4);
    prev = NIST_IV;
    pop_chk("nist0", npt[0], nct[0]);
    chk("nist0_literal", bus.out_pt, 128'h6bc1bee22e409f96e93d7e117393172a);
    for (int i = 1; i < 4; i++) pop_chk("nist", npt[i], nct[i]);
    tick();
    chk("nist_idle_vld", 128'(bus.out_valid), 128'd0);
    chk("nist_hold_pt", bus.out_pt, npt[3]);
    chk("nist_inflight_end", 128'(bus.inflight), 128'd0);
    chk("nist_err", 128'(bus.err), 128'd0);

    // Fill to 12, then push+pop at full
    load_iv(128'h0f0e0d0c0b0a09080706050403020100);
    prev = 128'h0f0e0d0c0b0a09080706050403020100;
    for (int k = 0; k < 12; k++) push(ctk(k));
    chk("full_inflight", 128'(bus.inflight), 128'd12);
    chk("full_err", 128'(bus.err), 128'd0);
    bus.ct_load = 1'b1;
    bus.ct      = ctk(12);
    pop_chk("pushpop", ptk(0), ctk(0));
    chk("pushpop_inflight", 128'(bus.inflight), 128'd12);
    chk("pushpop_err", 128'(bus.err), 128'd0);
    for (int k = 1; k < 13; k++) pop_chk("stream", ptk(k), ctk(k));
    tick();
    chk("stream_inflight", 128'(bus.inflight), 128'd0);
    chk("stream_err", 128'(bus.err), 128'd0);

    // Overflow: 13th push with no pop is dropped
    load_iv(128'h11111111222222223333333344444444);
    prev = 128'h11111111222222223333333344444444;
    for (int k = 20; k < 32; k++) push(ctk(k));
    push(ctk(99));
    chk("ovf_err", 128'(bus.err), 128'd1);
    chk("ovf_inflight", 128'(bus.inflight), 128'd12);
    n_out = 0;
    for (int k = 20; k < 32; k++) begin
      pop_chk("ovf_out", ptk(k), ctk(k));
      if (bus.out_valid) n_out++;
    end
    tick();
    chk("ovf_nout", 128'(n_out), 128'd12);
    chk("ovf_drained", 128'(bus.inflight), 128'd0);
    chk("ovf_no_extra", 128'(bus.out_valid), 128'd0);

    // Underflow leaves chain untouched
    do_reset();
    chk("rst2_err", 128'(bus.err), 128'd0);
    load_iv(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5);
    prev = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
    push(ctk(40));
    pop_chk("pre_udf", ptk(40), ctk(40));
    tick();
    bus.pt_valid = 1'b1;
    bus.pt_raw   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    tick();
    idle();
    chk("udf_err", 128'(bus.err), 128'd1);
    chk("udf_vld", 128'(bus.out_valid), 128'd0);
    chk("udf_hold_pt", bus.out_pt, ptk(40));
    chk("udf_inflight", 128'(bus.inflight), 128'd0);
    push(ctk(41));
    pop_chk("post_udf", ptk(41), ctk(41));

    // Late IV load is ignored
    do_reset();
    for (int k = 50; k < 53; k++) push(ctk(k));
    load_iv(128'h99999999999999999999999999999999);
    chk("late_iv_err", 128'(bus.err), 128'd1);
    chk("late_iv_inflight", 128'(bus.inflight), 128'd3);
    prev = '0;
    for (int k = 50; k < 53; k++) pop_chk("late_iv_out", ptk(k), ctk(k));

    // IV and first ct in the same cycle
    do_reset();
    chk("rst3_err", 128'(bus.err), 128'd0);
    bus.iv_load = 1'b1;
    bus.iv      = 128'h0123456789abcdef0123456789abcdef;
    push(ctk(60));
    chk("ivct_inflight", 128'(bus.inflight), 128'd1);
    chk("ivct_err", 128'(bus.err), 128'd0);
    prev = 128'h0123456789abcdef0123456789abcdef;
    pop_chk("ivct_out", ptk(60), ctk(60));

    // Async reset with 5 blocks in flight
    do_reset();
    load_iv(128'h55555555666666667777777788888888);
    prev = 128'h55555555666666667777777788888888;
    for (int k = 70; k < 76; k++) push(ctk(k));
    bus.iv_load = 1'b1;
    bus.iv      = 128'hffffffffffffffffffffffffffffffff;
    pop_chk("mid_pop", ptk(70), ctk(70));
    chk("mid_inflight", 128'(bus.inflight), 128'd5);
    chk("mid_err", 128'(bus.err), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_inflight", 128'(bus.inflight), 128'd0);
    chk("arst_vld", 128'(bus.out_valid), 128'd0);
    chk("arst_err", 128'(bus.err), 128'd0);
    chk("arst_pt", bus.out_pt, 128'd0);
    tick();
    rst = 1'b0;
    load_iv(128'h13579bdf2468ace013579bdf2468ace0);
    prev = 128'h13579bdf2468ace013579bdf2468ace0;
    push(ctk(80));
    push(ctk(81));
    chk("fresh_inflight", 128'(bus.inflight), 128'd2);
    pop_chk("fresh0", ptk(80), ctk(80));
    pop_chk("fresh1", ptk(81), ctk(81));
    tick();
    chk("fresh_err", 128'(bus.err), 128'd0);
    chk("fresh_inflight_end", 128'(bus.inflight), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
